countdown_unit: RTL and testbench

//  Registered down-counter stage that consumes the combinational decrement
//  (Out = A - 1) result every enabled cycle. Loads a start value via a

---
 rtl/countdown_unit.sv | 152 +++++++++++++++
 tb/tb_countdown_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_unit.sv
// Registered down-counter: loads a start value over valid/ready, decrements on tick,
// pulses done at zero. Define COUNTDOWN_RELOAD_EN for periodic auto-reload mode.
module countdown_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Decrement is modulo 2^WIDTH; the COUNT exit at 1 keeps it from wrapping.
    function automatic logic [WIDTH-1:0] dec_f(input logic [WIDTH-1:0] value);
        return value - ONE;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             load_fire_s;
    logic             last_tick_s;
    logic [WIDTH-1:0] expire_value_s;

    assign load_fire_s = load_valid && (state_q == ST_IDLE);
    assign last_tick_s = tick && (count_q == ONE);

`ifdef COUNTDOWN_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;

    // Reload register captures every accepted start value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= ZERO;
        end else begin
            reload_q <= reload_d;
        end
    end

    // Capture-on-accept next value for the reload register.
    always_comb begin
        reload_d = reload_q;
        if (load_fire_s) begin
            reload_d = load_value;
        end else begin
            reload_d = reload_q;
        end
    end

    assign expire_value_s = reload_q;
`else
    assign expire_value_s = ZERO;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= ZERO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid && (load_value != ZERO)) begin
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_tick_s) begin
`ifdef COUNTDOWN_RELOAD_EN
                    state_d = ST_COUNT;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_COUNT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter and done-pulse next values; abort outranks tick in COUNT.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    count_d = load_value;
                    done_d  = (load_value == ZERO);
                end else begin
                    count_d = count_q;
                    done_d  = 1'b0;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    count_d = ZERO;
                    done_d  = 1'b0;
                end else if (last_tick_s) begin
                    count_d = expire_value_s;
                    done_d  = 1'b1;
                end else if (tick) begin
                    count_d = dec_f(count_q);
                    done_d  = 1'b0;
                end else begin
                    count_d = count_q;
                    done_d  = 1'b0;
                end
            end
            default: begin
                count_d = ZERO;
                done_d  = 1'b0;
            end
        endcase
    end

    assign count      = count_q;
    assign done       = done_q;
    assign busy       = (state_q == ST_COUNT);
    assign load_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_countdown_unit.sv
// Directed self-checking bench for countdown_unit (WIDTH=32).
module tb_countdown_unit;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_value;
    logic        tick;
    logic        abort;
    logic [31:0] count;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_bad;

    countdown_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .tick       (tick),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_value = 32'd0;
        tick       = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({count, busy, done, load_ready} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_init: count=%0h busy=%b done=%b rdy=%b, want 0/0/0/1",
                     count, busy, done, load_ready);
        end
        rst_n = 1'b1;
        cyc();
        load_valid = 1'b1; load_value = 32'd5;
        cyc();
        load_valid = 1'b0; tick = 1'b1;
        cyc();
        n_cmp++;
        if (count !== 32'd4 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_precount: count=%0d busy=%b, want 4/1", count, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({count, busy, done, load_ready} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_async: count=%0h busy=%b done=%b rdy=%b, want 0/0/0/1",
                     count, busy, done, load_ready);
        end
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        cyc();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_nodone: done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    task automatic test_countdown();
        logic [31:0] exp_cnt [4];
        exp_cnt[0] = 32'd3; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd1; exp_cnt[3] = 32'd0;
        load_valid = 1'b1; load_value = 32'd3; tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            load_valid = 1'b0;
            n_cmp++;
            if (count !== exp_cnt[i] || done !== (i == 3) || busy !== (i != 3)
                || load_ready !== (i == 3)) begin
                n_bad++;
                $display("FAIL countdown[%0d]: count=%0d done=%b busy=%b rdy=%b, want %0d/%b/%b/%b",
                         i, count, done, busy, load_ready, exp_cnt[i], i == 3, i != 3, i == 3);
            end
        end
        cyc();
        n_cmp++;
        if (done !== 1'b0 || count !== 32'd0) begin
            n_bad++;
            $display("FAIL countdown_after: done=%b count=%0d, want 0/0", done, count);
        end
        idle_inputs();
    endtask

    task automatic test_load_zero();
        int busy_seen;
        busy_seen = 0;
        load_valid = 1'b1; load_value = 32'd0;
        cyc();
        load_valid = 1'b0;
        if (busy) busy_seen++;
        n_cmp++;
        if (done !== 1'b1 || count !== 32'd0 || load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL load0_pulse: done=%b count=%0d rdy=%b, want 1/0/1", done, count, load_ready);
        end
        cyc();
        if (busy) busy_seen++;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL load0_single: done=%b, want 0", done);
        end
        tick = 1'b1; abort = 1'b1;
        cyc();
        if (busy) busy_seen++;
        n_cmp++;
        if (busy_seen != 0 || count !== 32'd0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ignore: busy_seen=%0d count=%0d done=%b, want 0/0/0",
                     busy_seen, count, done);
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        logic [3:0] ticks;
        ticks = 4'b0101;
        load_valid = 1'b1; load_value = 32'd5;
        cyc();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick = ticks[i];
            cyc();
        end
        n_cmp++;
        if (count !== 32'd3 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pre: count=%0d busy=%b, want 3/1", count, busy);
        end
        tick = 1'b1; abort = 1'b1;
        cyc();
        idle_inputs();
        n_cmp++;
        if (count !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort: count=%0d busy=%b done=%b rdy=%b, want 0/0/0/1",
                     count, busy, done, load_ready);
        end
        cyc();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_nodone: done=%b, want 0", done);
        end
    endtask

    task automatic test_max_value();
        load_valid = 1'b1; load_value = 32'hFFFF_FFFF;
        cyc();
        load_valid = 1'b0; tick = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if (count !== 32'hFFFF_FFFD) begin
            n_bad++;
            $display("FAIL max_dec: count=%0h, want fffffffd", count);
        end
        tick = 1'b0; load_valid = 1'b1; load_value = 32'd7;
        cyc();
        n_cmp++;
        if (count !== 32'hFFFF_FFFD || load_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL load_in_count: count=%0h rdy=%b busy=%b, want fffffffd/0/1",
                     count, load_ready, busy);
        end
        load_valid = 1'b0; abort = 1'b1;
        cyc();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        load_valid = 1'b1; load_value = 32'd1;
        cyc();
        load_valid = 1'b0; tick = 1'b1;
        cyc();
`ifndef COUNTDOWN_RELOAD_EN
        n_cmp++;
        if (count !== 32'd0 || done !== 1'b1 || load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_done: count=%0d done=%b rdy=%b, want 0/1/1", count, done, load_ready);
        end
        load_valid = 1'b1; load_value = 32'd2; tick = 1'b0;
        cyc();
        load_valid = 1'b0;
        n_cmp++;
        if (count !== 32'd2 || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_reload: count=%0d busy=%b done=%b, want 2/1/0", count, busy, done);
        end
`endif
        abort = 1'b1;
        cyc();
        idle_inputs();
    endtask

`ifdef COUNTDOWN_RELOAD_EN
    task automatic test_reload();
        logic [31:0] exp_cnt [5];
        logic [4:0]  exp_done;
        exp_cnt[0] = 32'd1; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd1;
        exp_cnt[3] = 32'd2; exp_cnt[4] = 32'd1;
        exp_done = 5'b01010;
        load_valid = 1'b1; load_value = 32'd2;
        cyc();
        load_valid = 1'b0; tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_cmp++;
            if (count !== exp_cnt[i] || done !== exp_done[i] || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL reload[%0d]: count=%0d done=%b busy=%b, want %0d/%b/1",
                         i, count, done, busy, exp_cnt[i], exp_done[i]);
            end
        end
        abort = 1'b1;
        cyc();
        idle_inputs();
        n_cmp++;
        if (busy !== 1'b0 || count !== 32'd0) begin
            n_bad++;
            $display("FAIL reload_abort: busy=%b count=%0d, want 0/0", busy, count);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_countdown();
        test_load_zero();
        test_abort();
        test_max_value();
        test_back_to_back();
`ifdef COUNTDOWN_RELOAD_EN
        test_reload();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
